// File: rtl/bram_if_pkg.sv
// Shared definitions for the BRAM write/read side controllers: FSM encoding
// and default geometry.
package bram_if_pkg;

  localparam int DATA_BITS_DEF = 512;
  localparam int ADDR_BITS_DEF = 10;
  localparam int MEM_DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FINISH = 2'd2
  } bram_state_e;

endpackage

// File: rtl/bram_addr_gen.sv
// BRAM address generator: loads a base address, steps by one per request and
// wraps from mem_depth-1 back to 0.
module bram_addr_gen
  import bram_if_pkg::*;
#(
  parameter int address_bits = ADDR_BITS_DEF,
  parameter int mem_depth    = MEM_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load_i,
  input  logic [address_bits-1:0] base_i,
  input  logic                    step_i,
  output logic [address_bits-1:0] addr_o
);

  localparam logic [address_bits-1:0] LAST_ADDR = address_bits'(mem_depth - 1);

  logic [address_bits-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (step_i) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + address_bits'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/bram_write_module.sv
// Moves a burst of words from the receive FIFO into an external BRAM through
// port A, one registered write per accepted word.
module bram_write_module
  import bram_if_pkg::*;
#(
  parameter int data_bits    = DATA_BITS_DEF,
  parameter int address_bits = ADDR_BITS_DEF,
  parameter int mem_depth    = MEM_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start_wr_en,
  input  logic [address_bits-1:0] base_address,
  input  logic [address_bits:0]   wr_length,
  input  logic [data_bits-1:0]    fifo_rx_data,
  input  logic                    fifo_rx_valid,
  output logic                    fifo_rx_ready,
  output logic [address_bits-1:0] address_a,
  output logic [data_bits-1:0]    datain_a,
  output logic                    ena,
  output logic                    wea,
  output logic                    wr_busy,
  output logic                    wr_done,
  output logic                    wr_error
);

  localparam logic [address_bits:0] DEPTH_L = (address_bits + 1)'(mem_depth);

  bram_state_e             state_q;
  logic [address_bits:0]   len_q, cnt_q, cnt_d;
  logic [address_bits-1:0] addr_a_q, cur_addr;
  logic [data_bits-1:0]    din_q;
  logic                    ready_q, ena_q, wea_q, busy_q, done_q, err_q;
  logic                    hs, len_ok, load;

  assign hs     = (state_q == ST_WRITE) && fifo_rx_valid && ready_q;
  assign len_ok = (wr_length != '0) && (wr_length <= DEPTH_L);
  assign load   = (state_q == ST_IDLE) && start_wr_en && len_ok;
  assign cnt_d  = cnt_q + (address_bits + 1)'(1);

  bram_addr_gen #(
    .address_bits(address_bits),
    .mem_depth   (mem_depth)
  ) u_addr_gen (
    .clk   (clk),
    .resetn(resetn),
    .load_i(load),
    .base_i(base_address),
    .step_i(hs),
    .addr_o(cur_addr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_a_q <= '0;
      din_q    <= '0;
      ready_q  <= 1'b0;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ena_q  <= 1'b0;
      wea_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_wr_en) begin
            if (len_ok) begin
              len_q   <= wr_length;
              cnt_q   <= '0;
              err_q   <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (hs) begin
            ena_q    <= 1'b1;
            wea_q    <= 1'b1;
            addr_a_q <= cur_addr;
            din_q    <= fifo_rx_data;
            cnt_q    <= cnt_d;
            if (cnt_d == len_q) begin
              ready_q <= 1'b0;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          // First FINISH cycle carries the last BRAM write; done follows it.
          if (ena_q) begin
            done_q <= 1'b1;
          end else if (!start_wr_en) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rx_ready = ready_q;
  assign address_a     = addr_a_q;
  assign datain_a      = din_q;
  assign ena           = ena_q;
  assign wea           = wea_q;
  assign wr_busy       = busy_q;
  assign wr_done       = done_q;
  assign wr_error      = err_q;

endmodule

// File: tb/tb_bram_write_module.sv
// Directed bench for bram_write_module: FIFO source model, BRAM write log and
// hand-computed expectations for each burst scenario.
module tb_bram_write_module;

  localparam int DB = 32;
  localparam int AB = 10;
  localparam int MD = 1024;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_wr_en;
  logic [AB-1:0] base_address;
  logic [AB:0]   wr_length;
  logic [DB-1:0] fifo_rx_data;
  logic          fifo_rx_valid;
  logic          fifo_rx_ready;
  logic [AB-1:0] address_a;
  logic [DB-1:0] datain_a;
  logic          ena, wea, wr_busy, wr_done, wr_error;

  always #5 clk = ~clk;

  bram_write_module #(
    .data_bits   (DB),
    .address_bits(AB),
    .mem_depth   (MD)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_wr_en  (start_wr_en),
    .base_address (base_address),
    .wr_length    (wr_length),
    .fifo_rx_data (fifo_rx_data),
    .fifo_rx_valid(fifo_rx_valid),
    .fifo_rx_ready(fifo_rx_ready),
    .address_a    (address_a),
    .datain_a     (datain_a),
    .ena          (ena),
    .wea          (wea),
    .wr_busy      (wr_busy),
    .wr_done      (wr_done),
    .wr_error     (wr_error)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DB-1:0] fifo_q[$];
  logic [AB-1:0] wa_q[$];
  logic [DB-1:0] wd_q[$];
  int            wc_q[$];
  int            done_cnt, consumed, cyc, vidx, vlen, ew_bad;
  logic [15:0]   vpat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: handshake is judged on the values held across the rising edge.
  task automatic tick();
    logic hs;
    hs = fifo_rx_valid & fifo_rx_ready;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (hs && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      consumed++;
    end
    if (ena) begin
      wa_q.push_back(address_a);
      wd_q.push_back(datain_a);
      wc_q.push_back(cyc);
    end
    if (ena !== wea) ew_bad++;
    if (wr_done) done_cnt++;
    fifo_rx_valid = ((vidx < vlen) ? vpat[vidx] : 1'b1) && (fifo_q.size() > 0);
    fifo_rx_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    vidx++;
  endtask

  task automatic setup(input int nwords, input logic [15:0] pat, input int plen);
    fifo_q.delete();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0; consumed = 0; cyc = 0; vidx = 0; ew_bad = 0;
    vpat = pat; vlen = plen;
    for (int i = 0; i < nwords; i++) fifo_q.push_back(32'hA000 + 32'(i));
    fifo_rx_valid = 1'b0;
    fifo_rx_data  = '0;
  endtask

  task automatic start_burst(input logic [AB-1:0] base, input logic [AB:0] len, input bit hold);
    base_address = base;
    wr_length    = len;
    start_wr_en  = 1'b1;
    tick();
    if (!hold) start_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (wr_busy && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_timeout", {63'd0, wr_busy}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0; start_wr_en = 1'b0; base_address = '0; wr_length = '0;
    setup(0, 16'h0, 0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {address_a, datain_a, ena, wea, fifo_rx_ready, wr_busy, wr_done, wr_error}, 64'd0);
    resetn = 1'b1;
    tick();

    // Contiguous burst
    setup(6, 16'h0, 0);
    start_burst(10'h010, 11'd4, 1'b0);
    chk("a_busy", {63'd0, wr_busy}, 64'd1);
    wait_idle(40);
    chk("a_nwrites", wa_q.size(), 4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk($sformatf("a_addr%0d", i), wa_q[i], 64'h010 + 64'(i));
      chk($sformatf("a_data%0d", i), wd_q[i], 64'hA000 + 64'(i));
    end
    if (wc_q.size() == 4) chk("a_consecutive", wc_q[3] - wc_q[0], 3);
    chk("a_done", done_cnt, 1);
    chk("a_consumed", consumed, 4);
    chk("a_ena_wea", ew_bad, 0);

    // Wrap at top of memory
    setup(6, 16'h0, 0);
    start_burst(10'h3FE, 11'd4, 1'b0);
    wait_idle(40);
    chk("b_nwrites", wa_q.size(), 4);
    if (wa_q.size() == 4) begin
      chk("b_addr0", wa_q[0], 64'h3FE);
      chk("b_addr1", wa_q[1], 64'h3FF);
      chk("b_addr2", wa_q[2], 64'h000);
      chk("b_addr3", wa_q[3], 64'h001);
    end
    chk("b_done", done_cnt, 1);

    // Valid gaps: pattern 1,0,0,1,0,1
    setup(5, 16'b10_1001, 6);
    start_burst(10'h040, 11'd3, 1'b0);
    wait_idle(40);
    chk("c_nwrites", wa_q.size(), 3);
    if (wa_q.size() == 3) begin
      chk("c_data0", wd_q[0], 64'hA000);
      chk("c_data1", wd_q[1], 64'hA001);
      chk("c_data2", wd_q[2], 64'hA002);
      chk("c_addr2", wa_q[2], 64'h042);
      chk("c_gap1", wc_q[1] - wc_q[0], 3);
      chk("c_gap2", wc_q[2] - wc_q[1], 2);
    end
    chk("c_left_in_fifo", fifo_q.size(), 2);
    chk("c_done", done_cnt, 1);

    // Illegal lengths, then a legal start clears the error
    setup(2, 16'h0, 0);
    start_burst(10'h000, 11'd0, 1'b0);
    chk("d_err_len0", {63'd0, wr_error}, 64'd1);
    chk("d_busy_len0", {63'd0, wr_busy}, 64'd0);
    tick();
    chk("d_err_sticky", {63'd0, wr_error}, 64'd1);
    start_burst(10'h000, 11'd1025, 1'b0);
    chk("d_err_len1025", {63'd0, wr_error}, 64'd1);
    chk("d_busy_len1025", {63'd0, wr_busy}, 64'd0);
    tick();
    chk("d_no_writes", wa_q.size(), 0);
    start_burst(10'h005, 11'd1, 1'b0);
    chk("d_err_cleared", {63'd0, wr_error}, 64'd0);
    wait_idle(40);
    chk("d_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) chk("d_addr", wa_q[0], 64'h005);

    // Reset in the middle of an 8-beat burst
    setup(10, 16'h0, 0);
    start_burst(10'h100, 11'd8, 1'b0);
    for (int n = 0; n < 40 && wa_q.size() < 2; n++) tick();
    chk("e_two_writes", wa_q.size(), 2);
    #1 resetn = 1'b0;
    #1;
    chk("e_reset_outputs", {address_a, datain_a, ena, wea, fifo_rx_ready, wr_busy, wr_done, wr_error}, 64'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("e_no_more_writes", wa_q.size(), 2);
    chk("e_idle_busy", {63'd0, wr_busy}, 64'd0);
    chk("e_idle_ready", {63'd0, fifo_rx_ready}, 64'd0);

    // start_wr_en held high through FINISH
    setup(6, 16'h0, 0);
    start_burst(10'h020, 11'd2, 1'b1);
    for (int n = 0; n < 40 && done_cnt == 0; n++) tick();
    repeat (4) tick();
    chk("f_hold_busy", {63'd0, wr_busy}, 64'd1);
    chk("f_nwrites", wa_q.size(), 2);
    chk("f_done", done_cnt, 1);
    start_wr_en = 1'b0;
    tick();
    chk("f_released_idle", {63'd0, wr_busy}, 64'd0);
    repeat (3) tick();
    chk("f_no_second_burst", wa_q.size(), 2);
    chk("f_consumed", consumed, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_write_module.md
BRAM_WRITE_MODULE -- requirements
Module: bram_write_module

Interface
REQ-001 SHALL have parameter data_bits, default 512, BRAM/FIFO word width.
REQ-002 SHALL have parameter address_bits, default 10, BRAM address width.
REQ-003 SHALL have parameter mem_depth, default 1024, number of BRAM words (<= 2**address_bits).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_wr_en  input  1  level request to begin a write burst; sampled in IDLE only.
REQ-007 SHALL have port base_address  input  address_bits  first BRAM address of burst; captured at start.
REQ-008 SHALL have port wr_length  input  address_bits+1  beats in burst (1..mem_depth); captured at start.
REQ-009 SHALL have port fifo_rx_data  input  data_bits  word from receive data buffer.
REQ-010 SHALL have port fifo_rx_valid  input  1  fifo_rx_data holds a valid word.
REQ-011 SHALL have port fifo_rx_ready  output  1  block accepts word this cycle.
REQ-012 SHALL have port address_a  output  address_bits  BRAM port A address.
REQ-013 SHALL have port datain_a  output  data_bits  BRAM port A write data.
REQ-014 SHALL have port ena  output  1  BRAM port A enable.
REQ-015 SHALL have port wea  output  1  BRAM port A write enable.
REQ-016 SHALL have port wr_busy  output  1  high from start accept until return to IDLE.
REQ-017 SHALL have port wr_done  output  1  single-cycle pulse after last beat written.
REQ-018 SHALL have port wr_error  output  1  sticky; set on wr_length of 0 or > mem_depth; cleared by next accepted start.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, FINISH (2-bit encoding).
REQ-020 IDLE: start_wr_en=1 with legal wr_length -> capture base_address/wr_length, clear beat counter, go WRITE; illegal length -> set wr_error, stay IDLE.
REQ-021 WRITE: fifo_rx_ready SHALL be 1 (registered); handshake = fifo_rx_valid & fifo_rx_ready.
REQ-022 Each handshake SHALL register ena=1, wea=1, address_a=current address, datain_a=fifo_rx_data on the next edge (1-cycle latency); no handshake -> ena=0, wea=0 that cycle.
REQ-023 Current address SHALL increment by 1 per handshake and wrap mem_depth-1 -> 0.
REQ-024 Beat counter SHALL increment per handshake; handshake that makes counter equal wr_length -> fifo_rx_ready=0 next cycle, go FINISH.
REQ-025 No word SHALL be accepted beyond wr_length beats; valid gaps of any length SHALL be tolerated.
REQ-026 FINISH: ena/wea low, wr_done pulsed exactly one cycle on entry; go IDLE only when start_wr_en=0, else hold FINISH (no retrigger on held level).
REQ-027 start_wr_en deasserted during WRITE SHALL be ignored; burst completes.
REQ-028 wr_busy SHALL be 1 in WRITE and FINISH, 0 in IDLE.

Reset
REQ-029 resetn=0 SHALL asynchronously force state IDLE and all outputs 0 (address_a, datain_a, ena, wea, fifo_rx_ready, wr_busy, wr_done, wr_error), counters 0.
REQ-030 Reset mid-burst SHALL abort without further BRAM writes; first post-reset edge SHALL see IDLE.

Structure
REQ-031 FSM state encodings and default widths SHALL live in shared package bram_if_pkg, also used by read side.
REQ-032 Address wrap/increment SHALL be sub-module bram_addr_gen (load base, step, wrap at mem_depth); no other sub-modules.
REQ-033 Module SHALL contain no internal memory array; BRAM is external.

Verification
REQ-034 base=0x010, len=4, valid constant -> 4 writes at 0x010..0x013 on consecutive cycles, wr_done one pulse, 4 words consumed.
REQ-035 base=0x3FE, len=4 -> writes at 0x3FE,0x3FF,0x000,0x001.
REQ-036 len=3, valid toggles 1,0,0,1,0,1 -> exactly 3 writes in data order, ena=0 in gap cycles.
REQ-037 len=0 and len=1025 -> wr_error=1, no ena, state stays IDLE; next legal start clears wr_error.
REQ-038 resetn low after 2 of 8 beats -> all outputs 0 immediately, no further writes; start_wr_en held high through FINISH -> no second burst.
